// File: rtl/robot_pkg.sv
`default_nettype none
// ============================================================================
// Module  : robot_pkg
// Brief   : Shared constants and navigation state encoding for the robot core.
// Revision: 1.0 - initial release
// ============================================================================
package robot_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

  localparam int NUM_CH    = 3;
  localparam int CH_BUMP_L = 0;
  localparam int CH_BUMP_R = 1;
  localparam int CH_GROUND = 2;

  typedef enum logic [2:0] {
    NAV_IDLE       = 3'd0,
    NAV_FORWARD    = 3'd1,
    NAV_BACKUP     = 3'd2,
    NAV_TURN_LEFT  = 3'd3,
    NAV_TURN_RIGHT = 3'd4,
    NAV_STOP       = 3'd5
  } nav_state_e;

endpackage
`default_nettype wire

// File: rtl/robot_sensor_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module  : robot_sensor_conditioner_if
// Brief   : Raw sensor inputs and conditioned event/level outputs.
// Revision: 1.0 - initial release
// ============================================================================
interface robot_sensor_conditioner_if #(
  parameter int EVT_CNT_W = 8
);
  logic                 raw_bump_left;
  logic                 raw_bump_right;
  logic                 raw_ground;
  logic                 clear_counts;
  logic                 bump_left;
  logic                 bump_right;
  logic                 ground_detect;
  logic [EVT_CNT_W-1:0] left_count;
  logic [EVT_CNT_W-1:0] right_count;

  modport slave (
    input  raw_bump_left, raw_bump_right, raw_ground, clear_counts,
    output bump_left, bump_right, ground_detect, left_count, right_count
  );

  modport master (
    output raw_bump_left, raw_bump_right, raw_ground, clear_counts,
    input  bump_left, bump_right, ground_detect, left_count, right_count
  );
endinterface
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module  : debounce_channel
// Brief   : 2-flop synchroniser, symmetric debounce and registered rise pulse.
// Revision: 1.0 - initial release
// ============================================================================
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise,
  output logic o_rise_next
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_stable;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_accept;

  assign w_differ = r_sync ^ r_stable;
  assign w_accept = w_differ && (r_cnt == c_last_cnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      r_rise <= w_accept && r_sync;
      // Any sample matching the accepted level restarts the hold count.
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stable    = r_stable;
  assign o_rise      = r_rise;
  assign o_rise_next = w_accept && r_sync;

endmodule
`default_nettype wire

// File: rtl/robot_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : robot_sensor_conditioner
// Brief   : Debounced bumper press events, ground level and event counters.
// Revision: 1.0 - initial release
// ============================================================================
module robot_sensor_conditioner
  import robot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int EVT_CNT_W       = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  robot_sensor_conditioner_if.slave   bus
);

  logic [NUM_CH-1:0] w_raw;
  logic [NUM_CH-1:0] w_stable;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_rise_next;
  logic              w_unused;

  assign w_raw[CH_BUMP_L] = bus.raw_bump_left;
  assign w_raw[CH_BUMP_R] = bus.raw_bump_right;
  assign w_raw[CH_GROUND] = bus.raw_ground;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_chan (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_raw       (w_raw[gi]),
        .o_stable    (w_stable[gi]),
        .o_rise      (w_rise[gi]),
        .o_rise_next (w_rise_next[gi])
      );
    end

    // Counters step on the same edge that launches the bump pulse; clear wins.
    for (genvar gc = CH_BUMP_L; gc <= CH_BUMP_R; gc++) begin : g_cnt
      logic [EVT_CNT_W-1:0] r_count;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_count <= '0;
        end else if (bus.clear_counts) begin
          r_count <= '0;
        end else if (w_rise_next[gc] && (r_count != '1)) begin
          r_count <= r_count + EVT_CNT_W'(1);
        end
      end
    end
  endgenerate

  assign bus.bump_left     = w_rise[CH_BUMP_L];
  assign bus.bump_right    = w_rise[CH_BUMP_R];
  assign bus.ground_detect = w_stable[CH_GROUND];
  assign bus.left_count    = g_cnt[CH_BUMP_L].r_count;
  assign bus.right_count   = g_cnt[CH_BUMP_R].r_count;

  assign w_unused = &{1'b0, w_stable[CH_BUMP_R:CH_BUMP_L],
                      w_rise[CH_GROUND], w_rise_next[CH_GROUND]};

endmodule
`default_nettype wire

// File: tb/tb_robot_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : tb_robot_sensor_conditioner
// Brief   : Directed bench with a windowed reference model checked every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_robot_sensor_conditioner;

  localparam int D    = 4;
  localparam int EW   = 2;
  localparam int CMAX = (1 << EW) - 1;
  localparam bit [15:0] MASK = 16'((1 << D) - 1);

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  robot_sensor_conditioner_if #(.EVT_CNT_W(EW)) bus ();

  robot_sensor_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .EVT_CNT_W       (EW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests   = 0;
  int fails   = 0;
  int edge_no = 0;

  // Reference: a level is accepted once the last D synchronised samples all
  // disagree with the current accepted level.
  bit [7:0]  m_raw   [3];
  int        m_raw_n [3];
  bit [15:0] m_win   [3];
  int        m_win_n [3];
  bit        m_stable[3];
  bit        m_pulse [3];
  int        m_cnt   [2];

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_raw[c] = '0; m_raw_n[c] = 0; m_win[c] = '0; m_win_n[c] = 0;
      m_stable[c] = 1'b0; m_pulse[c] = 1'b0;
    end
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  task automatic model_step();
    bit [2:0] raw_now;
    bit       s;
    raw_now = {bus.raw_ground, bus.raw_bump_right, bus.raw_bump_left};
    for (int c = 0; c < 3; c++) begin
      m_raw[c] = {m_raw[c][6:0], raw_now[c]};
      if (m_raw_n[c] < 8) m_raw_n[c]++;
      s = (m_raw_n[c] >= 3) ? m_raw[c][2] : 1'b0;
      m_win[c] = {m_win[c][14:0], s};
      if (m_win_n[c] < 16) m_win_n[c]++;
      m_pulse[c] = 1'b0;
      if (m_win_n[c] >= D && (m_win[c] & MASK) == (m_stable[c] ? 16'h0 : MASK)) begin
        m_pulse[c]  = !m_stable[c];
        m_stable[c] = !m_stable[c];
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (bus.clear_counts) m_cnt[i] = 0;
      else if (m_pulse[i] && m_cnt[i] < CMAX) m_cnt[i]++;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, edge_no, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({bus.bump_left, bus.bump_right, bus.ground_detect,
                bus.left_count, bus.right_count});
  endfunction

  function automatic logic [31:0] model_vec();
    return 32'({m_pulse[0], m_pulse[1], m_stable[2], 2'(m_cnt[0]), 2'(m_cnt[1])});
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    edge_no++;
    @(negedge clk);
    check("cycle", dut_vec(), model_vec());
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic run_to(input int e);
    while (edge_no < e) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    ticks(2);
    reset_n = 1'b1;
    edge_no = 0;
  endtask

  int exp5[5] = '{1, 2, 3, 3, 3};
  int e0;

  initial begin
    bus.raw_bump_left  = 1'b0;
    bus.raw_bump_right = 1'b0;
    bus.raw_ground     = 1'b0;
    bus.clear_counts   = 1'b0;
    model_reset();
    @(negedge clk);
    ticks(2);
    check("reset_outputs", dut_vec(), 32'h0);
    reset_n = 1'b1;
    edge_no = 0;

    // Held left press: single pulse after edge 15
    run_to(9);
    bus.raw_bump_left = 1'b1;
    run_to(14);
    check("left_before_accept", 32'(bus.bump_left), 32'h0);
    tick();
    check("left_pulse_edge15", 32'(bus.bump_left), 32'h1);
    check("left_count_1", 32'(bus.left_count), 32'h1);
    tick();
    check("left_pulse_one_cycle", 32'(bus.bump_left), 32'h0);
    run_to(30);
    check("left_held_count", 32'(bus.left_count), 32'h1);
    bus.raw_bump_left = 1'b0;
    ticks(10);

    // Short right glitches never propagate
    repeat (5) begin
      bus.raw_bump_right = 1'b1;
      ticks(3);
      bus.raw_bump_right = 1'b0;
      ticks(3);
    end
    ticks(8);
    check("right_glitch_count", 32'(bus.right_count), 32'h0);

    // Ground level rise and fall
    do_reset();
    run_to(19);
    bus.raw_ground = 1'b1;
    run_to(24);
    check("ground_pre_rise", 32'(bus.ground_detect), 32'h0);
    tick();
    check("ground_rise_e25", 32'(bus.ground_detect), 32'h1);
    run_to(39);
    bus.raw_ground = 1'b0;
    run_to(44);
    check("ground_pre_fall", 32'(bus.ground_detect), 32'h1);
    tick();
    check("ground_fall_e45", 32'(bus.ground_detect), 32'h0);

    // Simultaneous presses
    do_reset();
    bus.raw_bump_left  = 1'b1;
    bus.raw_bump_right = 1'b1;
    for (int i = 0; i < 20 && !(bus.bump_left || bus.bump_right); i++) tick();
    check("both_pulse", 32'({bus.bump_left, bus.bump_right}), 32'h3);
    check("both_left_count", 32'(bus.left_count), 32'h1);
    check("both_right_count", 32'(bus.right_count), 32'h1);
    bus.raw_bump_left  = 1'b0;
    bus.raw_bump_right = 1'b0;
    ticks(10);

    // Saturation at 3, then clear coinciding with a pulse
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.raw_bump_left = 1'b1;
      ticks(8);
      check("left_sat_count", 32'(bus.left_count), 32'(exp5[i]));
      bus.raw_bump_left = 1'b0;
      ticks(8);
    end
    e0 = edge_no;
    bus.raw_bump_left = 1'b1;
    run_to(e0 + 5);
    bus.clear_counts = 1'b1;
    tick();
    bus.clear_counts = 1'b0;
    check("clear_pulse_seen", 32'(bus.bump_left), 32'h1);
    check("clear_wins", 32'(bus.left_count), 32'h0);
    ticks(4);
    bus.raw_bump_left = 1'b0;
    ticks(8);

    // Async reset mid-debounce, then recovery
    bus.raw_bump_left = 1'b1;
    ticks(8);
    bus.raw_bump_left = 1'b0;
    ticks(8);
    check("pre_reset_count", 32'(bus.left_count), 32'h1);
    e0 = edge_no;
    bus.raw_ground = 1'b1;
    run_to(e0 + 4);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_outputs", dut_vec(), 32'h0);
    ticks(2);
    reset_n = 1'b1;
    edge_no = 0;
    run_to(5);
    check("post_reset_ground_low", 32'(bus.ground_detect), 32'h0);
    tick();
    check("post_reset_ground_rise", 32'(bus.ground_detect), 32'h1);
    ticks(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
